// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor running in the reference clock domain.
// It pulses the PLL reset and waits for lock. Lock must hold continuously for
// a programmable time before the downstream system reset is released. The PLL
// is re-reset when lock times out or when lock is lost while running.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET_PLL | pll_rst held high for RST_CYCLES cycles
// WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT
// STABLE    | lock must stay high for STABLE_CYCLES consecutive cycles
// RUN       | system released; any lock drop re-resets the PLL
module pll_lock_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 16
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   input  logic       soft_rst_req,
   input  logic       lock_lost_clr,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       lock_lost,
   output logic [7:0] relock_count,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               locked_m;
   logic               locked_s;
   logic               relock_inc;
   logic               lost_set;

   assign state_o = state;

   // Two-flop synchronizer for the asynchronous PLL lock indication.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         locked_m <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         locked_m <= locked;
         locked_s <= locked_m;
      end
   end

   // Next-state decode; the soft restart overrides any transition but keeps lock-loss side effects.
   always_comb begin
      state_nxt  = state;
      relock_inc = 1'b0;
      lost_set   = 1'b0;
      case (state)
         RESET_PLL: begin
            if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt = STABLE;
            end else if (cnt == TIMEOUT_LAST) begin
               state_nxt  = RESET_PLL;
               relock_inc = 1'b1;
            end
         end
         STABLE: begin
            // a lock glitch only restarts the qualification window
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_nxt  = RESET_PLL;
               relock_inc = 1'b1;
               lost_set   = 1'b1;
            end
         end
         default: state_nxt = RESET_PLL;
      endcase
      if (soft_rst_req) state_nxt = RESET_PLL;
      // a soft restart while already in RESET_PLL re-arms the pulse
      cnt_nxt = (soft_rst_req || (state_nxt != state)) ? '0 : cnt + CNT_W'(1);
   end

   // State, shared counter and registered reset outputs advance together.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state     <= RESET_PLL;
         cnt       <= '0;
         pll_rst   <= 1'b1;
         sys_reset <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pll_rst   <= (state_nxt == RESET_PLL);
         sys_reset <= (state_nxt != RUN);
      end
   end

   // Software-visible status: sticky lock-loss flag (set beats clear) and saturating relock count.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_lost    <= 1'b0;
         relock_count <= 8'd0;
      end else begin
         if (lost_set) begin
            lock_lost <= 1'b1;
         end else if (lock_lost_clr) begin
            lock_lost <= 1'b0;
         end
         if (relock_inc && (relock_count != 8'hFF)) begin
            relock_count <= relock_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a cycle-indexed scoreboard.
// Expected output vectors {state, pll_rst, sys_reset, lock_lost, relock_count}
// are queued with the cycle at which they must hold and compared on the
// falling edge of that cycle.
module tb_pll_lock_supervisor;

   logic       refclk;
   logic       rst;
   logic       locked;
   logic       soft_rst_req;
   logic       lock_lost_clr;
   logic       pll_rst;
   logic       sys_reset;
   logic       lock_lost;
   logic [7:0] relock_count;
   logic [1:0] state_o;

   typedef struct {
      int          due;
      string       tag;
      logic [12:0] val;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   logic [12:0] obs;
   int          cyc;
   int          checks;
   int          errors;
   int          t0;

   pll_lock_supervisor #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .CNT_W        (16)
   ) dut (
      .refclk       (refclk),
      .rst          (rst),
      .locked       (locked),
      .soft_rst_req (soft_rst_req),
      .lock_lost_clr(lock_lost_clr),
      .pll_rst      (pll_rst),
      .sys_reset    (sys_reset),
      .lock_lost    (lock_lost),
      .relock_count (relock_count),
      .state_o      (state_o)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   always @(posedge refclk) cyc <= cyc + 1;

   // Scoreboard: compare every entry due at or before the current cycle.
   always @(negedge refclk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         cur = sb.pop_front();
         obs = {state_o, pll_rst, sys_reset, lock_lost, relock_count};
         checks++;
         assert (cur.due == cyc && obs === cur.val) else begin
            errors++;
            $error("FAIL %s: cycle %0d observed st=%0d prst=%0b srst=%0b lost=%0b cnt=%0d expected st=%0d prst=%0b srst=%0b lost=%0b cnt=%0d (due %0d)",
                   cur.tag, cyc, obs[12:11], obs[10], obs[9], obs[8], obs[7:0],
                   cur.val[12:11], cur.val[10], cur.val[9], cur.val[8], cur.val[7:0], cur.due);
         end
      end
   end

   task automatic chk(input int off, input string tag, input logic [1:0] st,
                      input logic pr, input logic sr, input logic ll, input logic [7:0] rc);
      exp_t e;
      e.due = cyc + off;
      e.tag = tag;
      e.val = {st, pr, sr, ll, rc};
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   initial begin
      cyc           = 0;
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      locked        = 1'b0;
      soft_rst_req  = 1'b0;
      lock_lost_clr = 1'b0;

      // reset state, then exactly four cycles of PLL reset
      step(3);
      chk(0, "reset_vals", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
      rst = 1'b0;
      chk(1, "prst_hold1", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
      chk(3, "prst_hold3", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0);
      chk(4, "prst_fall", 2'd1, 1'b0, 1'b1, 1'b0, 8'd0);
      step(4);

      // clean start: lock 3 cycles after pll_rst falls, release 11 edges later
      step(3);
      locked = 1'b1;
      chk(2, "sync_wait", 2'd1, 1'b0, 1'b1, 1'b0, 8'd0);
      chk(3, "stable_in", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
      chk(10, "pre_release", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0);
      chk(11, "release", 2'd3, 1'b0, 1'b0, 1'b0, 8'd0);
      step(11);

      // lock loss in RUN, then clear with no set pending
      locked = 1'b0;
      chk(2, "run_hold", 2'd3, 1'b0, 1'b0, 1'b0, 8'd0);
      chk(3, "lock_lost", 2'd0, 1'b1, 1'b1, 1'b1, 8'd1);
      step(3);
      lock_lost_clr = 1'b1;
      chk(1, "lost_clr", 2'd0, 1'b1, 1'b1, 1'b0, 8'd1);
      step(1);
      lock_lost_clr = 1'b0;
      step(3);

      // glitch in STABLE at cnt 5: back to WAIT_LOCK, then a full window
      chk(0, "relock_wait", 2'd1, 1'b0, 1'b1, 1'b0, 8'd1);
      locked = 1'b1;
      chk(3, "glitch_stable", 2'd2, 1'b0, 1'b1, 1'b0, 8'd1);
      step(8);
      locked = 1'b0;
      chk(2, "glitch_last", 2'd2, 1'b0, 1'b1, 1'b0, 8'd1);
      chk(3, "glitch_back", 2'd1, 1'b0, 1'b1, 1'b0, 8'd1);
      step(3);
      locked = 1'b1;
      chk(2, "glitch_sync", 2'd1, 1'b0, 1'b1, 1'b0, 8'd1);
      chk(3, "glitch_restb", 2'd2, 1'b0, 1'b1, 1'b0, 8'd1);
      chk(10, "glitch_full", 2'd2, 1'b0, 1'b1, 1'b0, 8'd1);
      chk(11, "glitch_run", 2'd3, 1'b0, 1'b0, 1'b0, 8'd1);
      step(11);

      // soft restart from RUN, then a second request extends the pulse
      soft_rst_req = 1'b1;
      chk(1, "soft_run", 2'd0, 1'b1, 1'b1, 1'b0, 8'd1);
      step(1);
      soft_rst_req = 1'b0;
      step(1);
      soft_rst_req = 1'b1;
      step(1);
      soft_rst_req = 1'b0;
      chk(3, "soft_extend", 2'd0, 1'b1, 1'b1, 1'b0, 8'd1);
      chk(4, "soft_ext_end", 2'd1, 1'b0, 1'b1, 1'b0, 8'd1);
      chk(13, "soft_rerun", 2'd3, 1'b0, 1'b0, 1'b0, 8'd1);
      step(13);

      // lock loss with simultaneous soft request and clear: set wins, count still bumps
      locked = 1'b0;
      step(2);
      soft_rst_req  = 1'b1;
      lock_lost_clr = 1'b1;
      chk(1, "set_wins", 2'd0, 1'b1, 1'b1, 1'b1, 8'd2);
      step(1);
      soft_rst_req = 1'b0;
      chk(1, "clr_after", 2'd0, 1'b1, 1'b1, 1'b0, 8'd2);
      step(1);
      lock_lost_clr = 1'b0;

      // timeouts: 4-cycle pulse every 24 cycles, count 3, 4, ... then saturate
      t0 = 0;
      chk(2, "to_rst", 2'd0, 1'b1, 1'b1, 1'b0, 8'd2);
      chk(3, "to_wait", 2'd1, 1'b0, 1'b1, 1'b0, 8'd2);
      chk(22, "to_last", 2'd1, 1'b0, 1'b1, 1'b0, 8'd2);
      chk(23, "timeout1", 2'd0, 1'b1, 1'b1, 1'b0, 8'd3);
      chk(26, "to1_pulse", 2'd0, 1'b1, 1'b1, 1'b0, 8'd3);
      chk(27, "to1_wait", 2'd1, 1'b0, 1'b1, 1'b0, 8'd3);
      chk(46, "to1_last", 2'd1, 1'b0, 1'b1, 1'b0, 8'd3);
      chk(47, "timeout2", 2'd0, 1'b1, 1'b1, 1'b0, 8'd4);
      chk(47 + 24 * 250, "sat_254", 2'd0, 1'b1, 1'b1, 1'b0, 8'd254);
      chk(47 + 24 * 251, "sat_255", 2'd0, 1'b1, 1'b1, 1'b0, 8'd255);
      chk(47 + 24 * 256, "sat_hold", 2'd0, 1'b1, 1'b1, 1'b0, 8'd255);
      chk(47 + 24 * 256 + 1, "sat_hold2", 2'd0, 1'b1, 1'b1, 1'b0, 8'd255);
      step(47 + 24 * 256 + 2);

      // async reset in the middle of STABLE
      locked = 1'b1;
      chk(3, "sat_stable", 2'd2, 1'b0, 1'b1, 1'b0, 8'd255);
      chk(5, "mid_stable", 2'd2, 1'b0, 1'b1, 1'b0, 8'd255);
      step(5);
      @(negedge refclk);
      #1;
      rst = 1'b1;
      #1;
      obs = {state_o, pll_rst, sys_reset, lock_lost, relock_count};
      checks++;
      assert (obs === 13'b00_1_1_0_00000000) else begin
         errors++;
         $error("FAIL async_rst: observed st=%0d prst=%0b srst=%0b lost=%0b cnt=%0d expected st=0 prst=1 srst=1 lost=0 cnt=0",
                obs[12:11], obs[10], obs[9], obs[8], obs[7:0]);
      end
      step(2);
      rst    = 1'b0;
      locked = 1'b0;
      step(2);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain: observed %0d pending entries expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
